// File: rtl/sys_arr_result_collector_if.sv
// Stream bundle for the result collector: skewed column strobes and data in, aligned rows out.
// Both directions share one interface; master is the array/sink side, slave is the collector.
interface sys_arr_result_collector_if #(
    parameter int row_width = 4,
    parameter int sum_width = 8
);
    logic [row_width-1:0]           active_out;
    logic [row_width*sum_width-1:0] mac_out;
    logic [row_width*sum_width-1:0] row_data;
    logic                           row_valid;
    logic                           row_ready;

    modport master (
        output active_out, mac_out, row_ready,
        input  row_data, row_valid
    );

    modport slave (
        input  active_out, mac_out, row_ready,
        output row_data, row_valid
    );
endinterface

// File: rtl/sys_arr_result_collector.sv
// Captures skewed per-column results into independent FIFOs and re-aligns them into complete rows
// on a registered valid/ready output, with sticky per-column overflow and a delivered-row counter.
module sys_arr_result_collector #(
    parameter int row_width = 4,
    parameter int sum_width = 8,
    parameter int depth     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    sys_arr_result_collector_if.slave bus,
    input  logic                      clr_i,
    output logic [row_width-1:0]      overflow_o,
    output logic [7:0]                row_count_o,
    output logic                      busy_o
);
    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;
    localparam int DW = row_width * sum_width;

    logic [sum_width-1:0] mem_q [row_width][depth];
    logic [PW-1:0]        wr_ptr_q [row_width];
    logic [PW-1:0]        wr_ptr_d [row_width];
    logic [PW-1:0]        rd_ptr_q [row_width];
    logic [PW-1:0]        rd_ptr_d [row_width];
    logic [CW-1:0]        cnt_q    [row_width];
    logic [CW-1:0]        cnt_d    [row_width];

    logic [DW-1:0]        row_data_q, row_data_d;
    logic                 row_valid_q, row_valid_d;
    logic [row_width-1:0] overflow_q, overflow_d;
    logic [7:0]           row_count_q, row_count_d;

    logic [row_width-1:0] nonempty;
    logic [row_width-1:0] full;
    logic [row_width-1:0] push_ok;
    logic [row_width-1:0] drop;
    logic [DW-1:0]        head_data;
    logic                 pop;
    logic                 handshake;

    always_comb begin
        nonempty  = '0;
        full      = '0;
        head_data = '0;
        for (int j = 0; j < row_width; j++) begin
            nonempty[j] = (cnt_q[j] != '0);
            full[j]     = (cnt_q[j] == CW'(depth));
            head_data[j*sum_width +: sum_width] = mem_q[j][rd_ptr_q[j]];
        end
        pop       = (&nonempty) && (!row_valid_q || bus.row_ready);
        handshake = row_valid_q && bus.row_ready;
        // A full FIFO still accepts a push when the same edge pops it.
        push_ok   = bus.active_out & (~full | {row_width{pop}});
        drop      = bus.active_out & full & {row_width{~pop}};
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        row_data_d  = row_data_q;
        row_valid_d = row_valid_q;
        overflow_d  = overflow_q | drop;
        row_count_d = handshake ? row_count_q + 8'd1 : row_count_q;

        for (int j = 0; j < row_width; j++) begin
            if (push_ok[j]) wr_ptr_d[j] = wr_ptr_q[j] + PW'(1);
            if (pop)        rd_ptr_d[j] = rd_ptr_q[j] + PW'(1);
            if (push_ok[j] && !pop)      cnt_d[j] = cnt_q[j] + CW'(1);
            else if (!push_ok[j] && pop) cnt_d[j] = cnt_q[j] - CW'(1);
        end

        if (pop) begin
            row_data_d  = head_data;
            row_valid_d = 1'b1;
        end else if (handshake) begin
            row_valid_d = 1'b0;
        end

        if (clr_i) begin
            for (int j = 0; j < row_width; j++) begin
                wr_ptr_d[j] = '0;
                rd_ptr_d[j] = '0;
                cnt_d[j]    = '0;
            end
            row_data_d  = '0;
            row_valid_d = 1'b0;
            overflow_d  = '0;
            row_count_d = '0;
        end
    end

    // Storage has no reset; occupancy counters alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int j = 0; j < row_width; j++) begin
            if (push_ok[j] && !clr_i)
                mem_q[j][wr_ptr_q[j]] <= bus.mac_out[j*sum_width +: sum_width];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < row_width; j++) begin
                wr_ptr_q[j] <= '0;
                rd_ptr_q[j] <= '0;
                cnt_q[j]    <= '0;
            end
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            overflow_q  <= '0;
            row_count_q <= '0;
        end else begin
            for (int j = 0; j < row_width; j++) begin
                wr_ptr_q[j] <= wr_ptr_d[j];
                rd_ptr_q[j] <= rd_ptr_d[j];
                cnt_q[j]    <= cnt_d[j];
            end
            row_data_q  <= row_data_d;
            row_valid_q <= row_valid_d;
            overflow_q  <= overflow_d;
            row_count_q <= row_count_d;
        end
    end

    assign bus.row_data  = row_data_q;
    assign bus.row_valid = row_valid_q;
    assign overflow_o    = overflow_q;
    assign row_count_o   = row_count_q;
    assign busy_o        = (|nonempty) | row_valid_q;
endmodule

// File: tb/tb_sys_arr_result_collector.sv
// Self-checking bench: cycle table for the skewed stream, then a row scoreboard for
// backpressure, overflow, simultaneous push/pop, reset/clear and counter wrap.
module tb_sys_arr_result_collector;
    logic       clk;
    logic       rst;
    logic       clr_i;
    logic [3:0] overflow_o;
    logic [7:0] row_count_o;
    logic       busy_o;

    sys_arr_result_collector_if #(.row_width(4), .sum_width(8)) bus ();

    sys_arr_result_collector #(.row_width(4), .sum_width(8), .depth(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .clr_i       (clr_i),
        .overflow_o  (overflow_o),
        .row_count_o (row_count_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mon_rows = 0;
    bit          mon_en = 1'b0;
    logic [31:0] sb[$];

    typedef struct {
        logic [3:0]  act;
        logic [31:0] mac;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [7:0]  exp_count;
        logic        exp_busy;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] colval(input int r, input int j);
        return 8'((r * 16 + j) & 255);
    endfunction

    function automatic logic [31:0] rowval(input int r);
        logic [31:0] d;
        for (int j = 0; j < 4; j++) d[j*8 +: 8] = colval(r, j);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.active_out = '0;
        bus.mac_out    = '0;
        clr_i          = 1'b0;
        rst            = 1'b1;
        tick();
        rst            = 1'b0;
        sb.delete();
        mon_rows       = 0;
    endtask

    // Skewed stream: column j of row r strobes at cycle r+j; first nexp rows are expected out.
    task automatic send_rows(input int r0, input int n, input int nexp);
        for (int c = 0; c < n + 3; c++) begin
            logic [3:0]  a;
            logic [31:0] m;
            a = '0;
            m = '0;
            for (int j = 0; j < 4; j++) begin
                int r;
                r = c - j;
                if (r >= 0 && r < n) begin
                    a[j] = 1'b1;
                    m[j*8 +: 8] = colval(r0 + r, j);
                    if (j == 3 && r < nexp) sb.push_back(rowval(r0 + r));
                end
            end
            bus.active_out = a;
            bus.mac_out    = m;
            tick();
        end
        bus.active_out = '0;
        bus.mac_out    = '0;
    endtask

    task automatic strobe(input int j, input int r);
        logic [31:0] m;
        m = '0;
        m[j*8 +: 8] = colval(r, j);
        bus.active_out = 4'(1 << j);
        bus.mac_out    = m;
        tick();
        bus.active_out = '0;
        bus.mac_out    = '0;
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.row_valid && bus.row_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_row actual=%h expected=none t=%0t", bus.row_data, $time);
            end else begin
                chk("row_order", bus.row_data, sb.pop_front());
            end
            mon_rows++;
        end
    end

    initial begin
        tbl[0] = '{4'b0001, 32'h00000000, 1'b0, 32'h00000000, 8'd0, 1'b1};
        tbl[1] = '{4'b0011, 32'h00000110, 1'b0, 32'h00000000, 8'd0, 1'b1};
        tbl[2] = '{4'b0111, 32'h00021120, 1'b0, 32'h00000000, 8'd0, 1'b1};
        tbl[3] = '{4'b1111, 32'h03122130, 1'b0, 32'h00000000, 8'd0, 1'b1};
        tbl[4] = '{4'b1110, 32'h13223100, 1'b1, 32'h03020100, 8'd0, 1'b1};
        tbl[5] = '{4'b1100, 32'h23320000, 1'b1, 32'h13121110, 8'd1, 1'b1};
        tbl[6] = '{4'b1000, 32'h33000000, 1'b1, 32'h23222120, 8'd2, 1'b1};
        tbl[7] = '{4'b0000, 32'h00000000, 1'b1, 32'h33323130, 8'd3, 1'b1};
        tbl[8] = '{4'b0000, 32'h00000000, 1'b0, 32'h33323130, 8'd4, 1'b0};
        tbl[9] = '{4'b0000, 32'h00000000, 1'b0, 32'h33323130, 8'd4, 1'b0};

        rst = 1'b1;
        clr_i = 1'b0;
        bus.active_out = '0;
        bus.mac_out = '0;
        bus.row_ready = 1'b0;
        #1;
        chk("reset_valid", 32'(bus.row_valid), 32'd0);
        chk("reset_data", bus.row_data, 32'd0);
        chk("reset_ovf", 32'(overflow_o), 32'd0);
        chk("reset_count", 32'(row_count_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);

        // 1: skewed stream, ready high, cycle-by-cycle table
        do_reset();
        bus.row_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.active_out = tbl[k].act;
            bus.mac_out    = tbl[k].mac;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("t1_valid[%0d]", k), 32'(bus.row_valid), 32'(tbl[k].exp_valid));
            chk($sformatf("t1_data[%0d]", k), bus.row_data, tbl[k].exp_data);
            chk($sformatf("t1_count[%0d]", k), 32'(row_count_o), 32'(tbl[k].exp_count));
            chk($sformatf("t1_busy[%0d]", k), 32'(busy_o), 32'(tbl[k].exp_busy));
        end
        chk("t1_ovf", 32'(overflow_o), 32'd0);

        mon_en = 1'b1;

        // 2: backpressure then drain
        do_reset();
        bus.row_ready = 1'b0;
        send_rows(0, 4, 4);
        for (int k = 0; k < 3; k++) begin
            chk("t2_hold_valid", 32'(bus.row_valid), 32'd1);
            chk("t2_hold_data", bus.row_data, 32'h03020100);
            tick();
        end
        chk("t2_ovf", 32'(overflow_o), 32'd0);
        bus.row_ready = 1'b1;
        repeat (4) tick();
        chk("t2_rows", 32'(mon_rows), 32'd4);
        chk("t2_valid_end", 32'(bus.row_valid), 32'd0);
        chk("t2_count", 32'(row_count_o), 32'd4);
        chk("t2_busy", 32'(busy_o), 32'd0);

        // 3: overflow with six rows against depth 4
        do_reset();
        bus.row_ready = 1'b0;
        send_rows(0, 6, 5);
        chk("t3_ovf", 32'(overflow_o), 32'hf);
        chk("t3_hold", bus.row_data, 32'h03020100);
        bus.row_ready = 1'b1;
        repeat (10) tick();
        chk("t3_rows", 32'(mon_rows), 32'd5);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        chk("t3_ovf_sticky", 32'(overflow_o), 32'hf);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("t3_ovf_clr", 32'(overflow_o), 32'd0);
        chk("t3_count_clr", 32'(row_count_o), 32'd0);

        // 4: push into full FIFOs on the same edge as a pop
        do_reset();
        bus.row_ready = 1'b0;
        send_rows(0, 5, 5);
        chk("t4_ovf_fill", 32'(overflow_o), 32'd0);
        bus.row_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) sb.push_back(rowval(5));
            strobe(j, 5);
        end
        repeat (8) tick();
        chk("t4_ovf", 32'(overflow_o), 32'd0);
        chk("t4_rows", 32'(mon_rows), 32'd6);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5a: async reset mid-operation
        do_reset();
        bus.row_ready = 1'b0;
        send_rows(0, 2, 0);
        strobe(0, 2);
        chk("t5_pre_valid", 32'(bus.row_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(bus.row_valid), 32'd0);
        chk("t5_rst_data", bus.row_data, 32'd0);
        chk("t5_rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        for (int j = 1; j < 4; j++) strobe(j, 7);
        repeat (3) tick();
        chk("t5_partial_valid", 32'(bus.row_valid), 32'd0);
        chk("t5_partial_busy", 32'(busy_o), 32'd1);
        strobe(0, 7);
        chk("t5_lat_e", 32'(bus.row_valid), 32'd0);
        tick();
        chk("t5_lat_e1", 32'(bus.row_valid), 32'd1);
        chk("t5_data", bus.row_data, rowval(7));

        // 5b: synchronous clear mid-operation
        do_reset();
        bus.row_ready = 1'b0;
        send_rows(0, 2, 0);
        strobe(0, 2);
        clr_i = 1'b1;
        #1;
        chk("t5c_before_edge", 32'(bus.row_valid), 32'd1);
        tick();
        clr_i = 1'b0;
        chk("t5c_valid", 32'(bus.row_valid), 32'd0);
        chk("t5c_data", bus.row_data, 32'd0);
        chk("t5c_busy", 32'(busy_o), 32'd0);
        for (int j = 1; j < 4; j++) strobe(j, 9);
        repeat (3) tick();
        chk("t5c_partial_valid", 32'(bus.row_valid), 32'd0);
        strobe(0, 9);
        tick();
        chk("t5c_valid_row", 32'(bus.row_valid), 32'd1);
        chk("t5c_data_row", bus.row_data, rowval(9));

        // 6: 256 rows at full rate, counter wraps
        do_reset();
        bus.row_ready = 1'b1;
        send_rows(0, 256, 256);
        repeat (4) tick();
        chk("t6_rows", 32'(mon_rows), 32'd256);
        chk("t6_count_wrap", 32'(row_count_o), 32'd0);
        chk("t6_last_data", bus.row_data, rowval(255));
        chk("t6_ovf", 32'(overflow_o), 32'd0);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sys_arr_result_collector.md
Name: sys_arr_result_collector

Overview:
- Sits at the bottom edge of the SysArray, the receiving end of its result stream.
- The array emits column results skewed in time: column j of a given row appears one cycle after column j-1. This block captures each column independently and re-aligns the columns into complete output rows.
- Completed rows are presented downstream on a registered valid/ready interface.
- Provides per-column buffering, sticky overflow detection and a delivered-row counter.

Parameters:
- row_width, 4, number of array columns N (matches SysArray row_width).
- sum_width, 8, bits per column result.
- depth, 4, entries per column capture FIFO (power of two, >= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- active_out  input  row_width  per-column result strobe from the array; bit j qualifies column j.
- mac_out  input  row_width*sum_width  column results; column j occupies bits [j*sum_width +: sum_width], column 0 in the LSBs.
- clr  input  1  synchronous clear of FIFOs, row register, overflow and row_count.
- row_ready  input  1  downstream accepts row_data.
- row_data  output  row_width*sum_width  aligned output row, same packing as mac_out.
- row_valid  output  1  row_data holds a valid row.
- overflow  output  row_width  sticky per-column drop flag.
- row_count  output  8  number of rows delivered (handshakes), modulo 256.
- busy  output  1  any column FIFO non-empty OR row_valid.

Behaviour:
- Reset (async, rst=1):
  - All FIFOs empty.
  - row_data=0, row_valid=0, overflow=0, row_count=0, busy=0.
  - Takes effect immediately, mid-operation included; pending and partial rows are discarded.
- clr=1 at an edge: same effect as reset, applied synchronously. clr has priority over push, pop and handshake in that cycle.
- Push: at each edge where active_out[j]=1, mac_out column j is written into column FIFO j.
  - Columns are independent; no assumption on skew amount or order.
- Pop condition: all column FIFOs non-empty AND (row_valid=0 OR row_ready=1).
  - On a pop, one entry is taken from every column FIFO simultaneously and loaded into the row_data register.
  - row_valid is set at the same edge.
- Handshake: row_valid AND row_ready at an edge delivers the row.
  - row_count increments, wrapping 255->0.
  - If no pop occurs at that edge, row_valid clears and row_data holds its last value.
- Throughput: one row per cycle with row_ready held high.
- Latency: if the final missing column is sampled at edge E, row_valid=1 after edge E+1 (assuming the row register is free).
- Hold: while row_valid=1 and row_ready=0, row_data and row_valid remain stable.
- Full FIFO j with push and no pop in the same cycle:
  - The new data is dropped and overflow[j] is set.
  - overflow[j] stays set until rst or clr.
  - FIFO contents are unaffected.
- Full FIFO j with push and pop in the same cycle: the push is accepted and no overflow occurs.
- Empty FIFO: never popped. A partial row (some columns missing) waits indefinitely; there is no timeout.
- FIFO pointers wrap modulo depth. Occupancy counters are log2(depth)+1 bits.
- busy is combinational from FIFO occupancies and row_valid.

Test Plan:
1. Skewed stream, row_ready=1: rows r=0..3, active_out[j] pulses at cycle r+j carrying value 16r+j.
   -> row_data sequence 32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130 on consecutive valid cycles.
   -> row_count=4, overflow=0, busy=0 at end.
2. Backpressure: same stimulus with row_ready=0.
   -> row_valid=1 with 32'h03020100 held stable, no overflow.
   -> Then row_ready=1 drains all four rows in 4 consecutive cycles in order; row_count=4.
3. Overflow: row_ready=0, six skewed rows pushed (depth=4).
   -> Row 0 is in the register and rows 1-4 are in the FIFOs.
   -> Row 5 is dropped: overflow=4'b1111.
   -> Draining yields exactly 5 rows (r=0..4); overflow stays set until clr.
4. Simultaneous push/pop on full FIFOs: fill all FIFOs with row_ready=0, then assert row_ready=1 in the same cycle as the next column-0 strobe.
   -> Push accepted, overflow[0]=0, data order preserved.
5. Reset mid-operation: two rows buffered plus a partial row (column 0 only); pulse rst between edges.
   -> Outputs go to 0 immediately without a clock edge.
   -> After release, no row emerges until 4 fresh column strobes arrive.
   -> Repeat with clr: zeroed at the next edge.
6. Counter wrap: 256 rows streamed with row_ready=1.
   -> row_count returns to 0; row 255 is delivered with correct data; overflow=0.
